mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM (IR3) register outputs; produces the MEM/WB (IR4) register contents and the branch redirect.
- Holds an internal doubleword data memory with a configurable access latency.
- Stalls upstream while a load or store is in flight and inserts bubbles into MEM/WB until the access completes.

Parameters:
- MEM_DEPTH, 64: number of 64-bit doubleword entries; power of two.
- MEM_LATENCY, 2: stall cycles per load/store; must be >= 1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RegWrite_IR3, MemtoReg_IR3, Branch_IR3, MemRead_IR3, MemWrite_IR3  in  1 each  control bits from EX/MEM.
- out_IR3  in  64  branch target address.
- zero_IR3  in  1  ALU zero flag.
- Result_IR3  in  64  ALU result, used as the memory byte address.
- readData2_IR3  in  64  store data.
- instb_IR3  in  5  destination register (rd).
- PCSrc  out  1  branch taken, combinational.
- branch_target  out  64  redirect PC, combinational.
- stall  out  1  upstream hold request, combinational.
- RegWrite_IR4, MemtoReg_IR4  out  1 each  MEM/WB control.
- readData_IR4  out  64  load data.
- Result_IR4  out  64  ALU result forwarded to WB.
- instb_IR4  out  5  rd forwarded to WB.
- misaligned_IR4  out  1  error flag for the instruction now in MEM/WB.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: all IR4 outputs are 0.
  - Control: FSM goes to IDLE, counter = 0, any pending store is discarded.
  - Memory array contents are not affected.
- Combinational outputs:
  - PCSrc = Branch_IR3 & zero_IR3.
  - branch_target = out_IR3.
- Memory addressing:
  - Index = Result_IR3[log2(MEM_DEPTH)+2 : 3].
  - Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*8.
- Definitions:
  - memop = MemRead_IR3 | MemWrite_IR3.
  - aligned = (Result_IR3[2:0] == 0).
- FSM states: IDLE, BUSY.
- IDLE, non-memop: at the next edge, IR4 is loaded from IR3 (RegWrite, MemtoReg, Result, instb), readData_IR4 = 0, misaligned_IR4 = 0. stall = 0. Latency is 1 cycle.
- IDLE, memop and misaligned:
  - No memory access and no stall.
  - At the next edge: RegWrite_IR4 = 0, MemtoReg_IR4 = 0, misaligned_IR4 = 1, readData_IR4 = 0. Result_IR4 and instb_IR4 are loaded normally.
- IDLE, memop and aligned:
  - stall = 1.
  - At edge E0: capture index, store data, rd, Result and control into internal registers; counter = MEM_LATENCY-1; go to BUSY; load a bubble into IR4 (all IR4 outputs 0).
- BUSY, counter != 0:
  - stall = 1.
  - At each edge: counter decrements and IR4 receives a bubble.
  - IR3 inputs are ignored; only the captured values are used.
- BUSY, counter == 0:
  - stall = 0.
  - At this edge (E0+MEM_LATENCY) the access is performed:
    - Store: write mem[index].
    - Load: readData_IR4 = mem[index].
  - IR4 is loaded from the captured values and the FSM returns to IDLE.
  - Upstream advances on the same edge.
- Stall count: a load/store asserts stall for exactly MEM_LATENCY cycles and stays in the stage for MEM_LATENCY+1 cycles.
- MemRead and MemWrite both 1: treated as a store. readData_IR4 = 0 and RegWrite_IR4 follows the captured RegWrite_IR3.
- Load writeback: RegWrite_IR4 = RegWrite_IR3 and MemtoReg_IR4 = MemtoReg_IR3, both as captured.
- Back-to-back memops: the FSM returns to IDLE before re-accepting, so there is at least one stall-free cycle between accepted requests.
- Reset mid-BUSY: a captured store never commits and the FSM returns to IDLE immediately.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs -> all IR4 outputs 0, stall=0. Release reset -> IDLE.
- ALU pass-through: RegWrite=1, Result=0x1234, instb=7, no memop -> Result_IR4=0x1234, instb_IR4=7, RegWrite_IR4=1 after 1 edge; stall never 1.
- Store then load (MEM_LATENCY=2):
  - Store: sd 0xDEADBEEFCAFEF00D to 0x10 -> stall=1 for 2 cycles; IR4 bubbles.
  - Load: ld 0x10 with rd=5, RegWrite=1, MemtoReg=1 -> at E0+1 RegWrite_IR4=0; at E0+2 readData_IR4=0xDEADBEEFCAFEF00D, instb_IR4=5, RegWrite_IR4=1.
- Branch: Branch=1, zero=1, out=0x400 -> PCSrc=1, branch_target=0x400 in the same cycle. Then zero=0 -> PCSrc=0.
- Misaligned and wrap:
  - ld from 0x13 -> no stall, misaligned_IR4=1, RegWrite_IR4=0.
  - sd 0x55 to 0x200, then ld 0x0 (MEM_DEPTH=64) -> readData_IR4=0x55.
- Reset mid-store:
  - sd 0x1111 to 0x20 completes.
  - Then sd 0x2222 to 0x20; pulse reset low during BUSY.
  - Then ld 0x20 -> readData_IR4=0x1111.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage with multi-cycle doubleword data memory
module mem_stage #(
  parameter int MEM_DEPTH   = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_IR3,
  input  logic        MemtoReg_IR3,
  input  logic        Branch_IR3,
  input  logic        MemRead_IR3,
  input  logic        MemWrite_IR3,
  input  logic [63:0] out_IR3,
  input  logic        zero_IR3,
  input  logic [63:0] Result_IR3,
  input  logic [63:0] readData2_IR3,
  input  logic [4:0]  instb_IR3,
  output logic        PCSrc,
  output logic [63:0] branch_target,
  output logic        stall,
  output logic        RegWrite_IR4,
  output logic        MemtoReg_IR4,
  output logic [63:0] readData_IR4,
  output logic [63:0] Result_IR4,
  output logic [4:0]  instb_IR4,
  output logic        misaligned_IR4
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           memop, aligned, accept, done, mem_we;

  // Request captured at acceptance; IR3 is ignored while BUSY
  logic [AW-1:0]  idx_q;
  logic [63:0]    wdata_q;
  logic [63:0]    result_q;
  logic [4:0]     rd_q;
  logic           regwrite_q, memtoreg_q, memread_q, memwrite_q;

  logic [63:0]    mem [MEM_DEPTH];

  assign memop         = MemRead_IR3 | MemWrite_IR3;
  assign aligned       = (Result_IR3[2:0] == 3'b000);
  assign accept        = (state_q == IDLE) && memop && aligned;
  assign done          = (state_q == BUSY) && (cnt_q == '0);
  assign PCSrc         = Branch_IR3 & zero_IR3;
  assign branch_target = out_IR3;

  // State and latency counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: accept aligned memops in IDLE, count down in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CW'(MEM_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: hold upstream until the final access cycle; stall is held low during reset
  always_comb begin
    stall  = 1'b0;
    mem_we = done && memwrite_q;
    if (reset) stall = accept || ((state_q == BUSY) && (cnt_q != '0));
  end

  // Capture the accepted request so later IR3 changes cannot disturb it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else if (accept) begin
      idx_q      <= Result_IR3[AW+2:3];
      wdata_q    <= readData2_IR3;
      result_q   <= Result_IR3;
      rd_q       <= instb_IR3;
      regwrite_q <= RegWrite_IR3;
      memtoreg_q <= MemtoReg_IR3;
      memread_q  <= MemRead_IR3;
      memwrite_q <= MemWrite_IR3;
    end
  end

  // Data memory write port; contents survive reset, and a reset FSM cannot commit
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  // MEM/WB register: pass-through, misaligned flag, bubble, or completed access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite_IR4   <= 1'b0;
      MemtoReg_IR4   <= 1'b0;
      readData_IR4   <= '0;
      Result_IR4     <= '0;
      instb_IR4      <= '0;
      misaligned_IR4 <= 1'b0;
    end else if (state_q == IDLE && !memop) begin
      RegWrite_IR4   <= RegWrite_IR3;
      MemtoReg_IR4   <= MemtoReg_IR3;
      readData_IR4   <= '0;
      Result_IR4     <= Result_IR3;
      instb_IR4      <= instb_IR3;
      misaligned_IR4 <= 1'b0;
    end else if (state_q == IDLE && !aligned) begin
      RegWrite_IR4   <= 1'b0;
      MemtoReg_IR4   <= 1'b0;
      readData_IR4   <= '0;
      Result_IR4     <= Result_IR3;
      instb_IR4      <= instb_IR3;
      misaligned_IR4 <= 1'b1;
    end else if (done) begin
      RegWrite_IR4   <= regwrite_q;
      MemtoReg_IR4   <= memtoreg_q;
      readData_IR4   <= (memread_q && !memwrite_q) ? mem[idx_q] : '0;
      Result_IR4     <= result_q;
      instb_IR4      <= rd_q;
      misaligned_IR4 <= 1'b0;
    end else begin
      RegWrite_IR4   <= 1'b0;
      MemtoReg_IR4   <= 1'b0;
      readData_IR4   <= '0;
      Result_IR4     <= '0;
      instb_IR4      <= '0;
      misaligned_IR4 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

  localparam int MEM_DEPTH   = 64;
  localparam int MEM_LATENCY = 2;

  logic        clk, reset;
  logic        RegWrite_IR3, MemtoReg_IR3, Branch_IR3, MemRead_IR3, MemWrite_IR3;
  logic [63:0] out_IR3, Result_IR3, readData2_IR3;
  logic        zero_IR3;
  logic [4:0]  instb_IR3;
  logic        PCSrc, stall;
  logic [63:0] branch_target;
  logic        RegWrite_IR4, MemtoReg_IR4, misaligned_IR4;
  logic [63:0] readData_IR4, Result_IR4;
  logic [4:0]  instb_IR4;

  mem_stage #(.MEM_DEPTH(MEM_DEPTH), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_IR3(RegWrite_IR3), .MemtoReg_IR3(MemtoReg_IR3), .Branch_IR3(Branch_IR3),
    .MemRead_IR3(MemRead_IR3), .MemWrite_IR3(MemWrite_IR3),
    .out_IR3(out_IR3), .zero_IR3(zero_IR3), .Result_IR3(Result_IR3),
    .readData2_IR3(readData2_IR3), .instb_IR3(instb_IR3),
    .PCSrc(PCSrc), .branch_target(branch_target), .stall(stall),
    .RegWrite_IR4(RegWrite_IR4), .MemtoReg_IR4(MemtoReg_IR4), .readData_IR4(readData_IR4),
    .Result_IR4(Result_IR4), .instb_IR4(instb_IR4), .misaligned_IR4(misaligned_IR4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mis;
    logic [4:0]  rd;
    logic [63:0] res;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [MEM_DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Pop the next expected MEM/WB contents and compare every field
  task automatic chk_ir4(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".RegWrite"},   {63'd0, RegWrite_IR4},   {63'd0, e.rw});
      chk({tag, ".MemtoReg"},   {63'd0, MemtoReg_IR4},   {63'd0, e.mtr});
      chk({tag, ".misaligned"}, {63'd0, misaligned_IR4}, {63'd0, e.mis});
      chk({tag, ".instb"},      {59'd0, instb_IR4},      {59'd0, e.rd});
      chk({tag, ".Result"},     Result_IR4,              e.res);
      chk({tag, ".readData"},   readData_IR4,            e.data);
    end
  endtask

  task automatic drive_nop();
    RegWrite_IR3 = 0; MemtoReg_IR3 = 0; Branch_IR3 = 0; MemRead_IR3 = 0; MemWrite_IR3 = 0;
    out_IR3 = '0; zero_IR3 = 0; Result_IR3 = '0; readData2_IR3 = '0; instb_IR3 = '0;
  endtask

  task automatic scramble();
    RegWrite_IR3  = 1'($urandom_range(0, 1));
    MemtoReg_IR3  = 1'($urandom_range(0, 1));
    MemRead_IR3   = 1'($urandom_range(0, 1));
    MemWrite_IR3  = 1'($urandom_range(0, 1));
    Result_IR3    = {$urandom, $urandom};
    readData2_IR3 = {$urandom, $urandom};
    instb_IR3     = 5'($urandom);
  endtask

  // Present one instruction, predict its MEM/WB sequence, and walk it through the stage
  task automatic issue(input string tag, input logic rw, input logic mtr, input logic mr,
                       input logic mw, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] rd);
    int   nstall;
    int   idx;
    exp_t e;
    RegWrite_IR3 = rw; MemtoReg_IR3 = mtr; MemRead_IR3 = mr; MemWrite_IR3 = mw;
    Branch_IR3 = 0; zero_IR3 = 0; out_IR3 = '0;
    Result_IR3 = addr; readData2_IR3 = wdata; instb_IR3 = rd;
    idx = int'(addr[8:3]);
    nstall = 0;
    if (!(mr || mw)) begin
      e = '{rw: rw, mtr: mtr, mis: 1'b0, rd: rd, res: addr, data: 64'd0};
      exp_q.push_back(e);
    end else if (addr[2:0] != 3'b000) begin
      e = '{rw: 1'b0, mtr: 1'b0, mis: 1'b1, rd: rd, res: addr, data: 64'd0};
      exp_q.push_back(e);
    end else begin
      nstall = MEM_LATENCY;
      for (int i = 0; i < MEM_LATENCY; i++) exp_q.push_back('0);
      e = '{rw: rw, mtr: mtr, mis: 1'b0, rd: rd, res: addr,
            data: (mr && !mw) ? model_mem[idx] : 64'd0};
      exp_q.push_back(e);
      if (mw) model_mem[idx] = wdata;
    end
    for (int c = 0; c <= nstall; c++) begin
      if (c > 0) scramble();
      #1;
      chk({tag, ".stall"}, {63'd0, stall}, {63'd0, (c < nstall)});
      @(posedge clk); #1;
      chk_ir4(tag);
    end
  endtask

  initial begin
    // Reset held with arbitrary inputs
    reset = 0;
    scramble();
    Branch_IR3 = 0; zero_IR3 = 0; out_IR3 = 64'h0;
    MemRead_IR3 = 1; Result_IR3 = 64'h40;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    chk("reset.stall", {63'd0, stall}, 64'd0);
    chk_ir4("reset");
    drive_nop();
    reset = 1;

    // ALU pass-through
    issue("alu", 1, 0, 0, 0, 64'h1234, 64'h0, 5'd7);

    // Branch resolution is combinational
    drive_nop();
    Branch_IR3 = 1; zero_IR3 = 1; out_IR3 = 64'h400;
    #1;
    chk("br.PCSrc", {63'd0, PCSrc}, 64'd1);
    chk("br.target", branch_target, 64'h400);
    zero_IR3 = 0;
    #1;
    chk("br_nz.PCSrc", {63'd0, PCSrc}, 64'd0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    chk_ir4("br");

    // Store then load
    issue("sd10", 0, 0, 0, 1, 64'h10, 64'hDEADBEEFCAFEF00D, 5'd0);
    issue("ld10", 1, 1, 1, 0, 64'h10, 64'h0, 5'd5);

    // Misaligned load and store
    issue("ld13", 1, 1, 1, 0, 64'h13, 64'h0, 5'd9);
    issue("sd1c", 1, 0, 0, 1, 64'h1C, 64'hBAD, 5'd3);

    // Address wrap
    issue("sd200", 0, 0, 0, 1, 64'h200, 64'h55, 5'd0);
    issue("ld0", 1, 1, 1, 0, 64'h0, 64'h0, 5'd11);

    // Read+write together behaves as a store and keeps captured RegWrite
    issue("rw_both", 1, 0, 1, 1, 64'h38, 64'hA5A5, 5'd12);
    issue("ld38", 1, 1, 1, 0, 64'h38, 64'h0, 5'd13);

    // Reset during a pending store
    issue("sd1111", 0, 0, 0, 1, 64'h20, 64'h1111, 5'd0);
    RegWrite_IR3 = 0; MemtoReg_IR3 = 0; MemRead_IR3 = 0; MemWrite_IR3 = 1;
    Result_IR3 = 64'h20; readData2_IR3 = 64'h2222; instb_IR3 = 5'd0;
    #1;
    chk("sd2222.stall0", {63'd0, stall}, 64'd1);
    exp_q.push_back('0);
    @(posedge clk); #1;
    chk_ir4("sd2222.bubble");
    chk("sd2222.stall1", {63'd0, stall}, 64'd1);
    #2 reset = 0;
    #1;
    exp_q.push_back('0);
    chk_ir4("midreset");
    chk("midreset.stall", {63'd0, stall}, 64'd0);
    #1 reset = 1;
    drive_nop();
    #1;
    chk("postreset.stall", {63'd0, stall}, 64'd0);
    exp_q.push_back('0);
    @(posedge clk); #1;
    chk_ir4("postreset");
    issue("ld20", 1, 1, 1, 0, 64'h20, 64'h0, 5'd6);

    // Back-to-back pass-through after loads
    issue("alu2", 1, 1, 0, 0, 64'hFFFF_0000_1234_5678, 64'h0, 5'd31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
